// File: rtl/l2_port_scheduler_pkg.sv
// Shared types for the L2 port scheduler: LC-3b word/line types and the arbiter state.
package l2_port_scheduler_pkg;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_mem_data;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D
  } l2_sched_state_t;

endpackage

// File: rtl/l2_sched_control.sv
// Arbitration FSM for the shared L2 port: picks I or D in IDLE, holds the owner until
// l2_mem_resp, and bounds I-cache starvation with a saturating grant counter.
module l2_sched_control
  import l2_port_scheduler_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            i_pmem_read,
  input  logic            d_pmem_read,
  input  logic            d_pmem_write,
  input  logic            l2_mem_resp,
  output logic            load_i,
  output logic            load_d,
  output logic            clear,
  output logic            i_pmem_resp,
  output logic            d_pmem_resp,
  output l2_sched_state_t state
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  l2_sched_state_t  state_q, state_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             d_req;
  logic             force_i;

  assign d_req   = d_pmem_read | d_pmem_write;
  assign force_i = i_pmem_read && (starve_cnt_q == STARVE_MAX);
  assign state   = state_q;

  // Next-state, grant and response decode.
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    load_i       = 1'b0;
    load_d       = 1'b0;
    clear        = 1'b0;
    i_pmem_resp  = 1'b0;
    d_pmem_resp  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (force_i || (i_pmem_read && !d_req)) begin
          load_i       = 1'b1;
          state_d      = BUSY_I;
          starve_cnt_d = '0;
        end else if (d_req) begin
          load_d  = 1'b1;
          state_d = BUSY_D;
          if (i_pmem_read && (starve_cnt_q != STARVE_MAX)) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
          end
        end
        // No I-cache demand means nobody is being starved.
        if (!i_pmem_read) begin
          starve_cnt_d = '0;
        end
      end
      BUSY_I: begin
        if (l2_mem_resp) begin
          i_pmem_resp = 1'b1;
          clear       = 1'b1;
          state_d     = IDLE;
        end
      end
      BUSY_D: begin
        if (l2_mem_resp) begin
          d_pmem_resp = 1'b1;
          clear       = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and starvation counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: rtl/l2_port_scheduler.sv
// Shares the single L2 port between the I-cache and D-cache miss paths. L2 request,
// address and write data come straight from registers loaded at grant time.
// Optional build macro L2_SCHED_PERF_EN adds saturating grant/conflict counters.
module l2_port_scheduler
  import l2_port_scheduler_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
`ifdef L2_SCHED_PERF_EN
  ,
  parameter int unsigned PERF_W = 16
`endif
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_pmem_read,
  input  lc3b_word     i_pmem_address,
  input  logic         d_pmem_read,
  input  logic         d_pmem_write,
  input  lc3b_word     d_pmem_address,
  input  lc3b_mem_data d_pmem_wdata,
  input  logic         l2_mem_resp,
  input  lc3b_mem_data l2_mem_rdata,
  output logic         i_pmem_resp,
  output logic         d_pmem_resp,
  output lc3b_mem_data i_pmem_rdata,
  output lc3b_mem_data d_pmem_rdata,
  output logic         l2_mem_read,
  output logic         l2_mem_write,
  output lc3b_word     l2_mem_address,
  output lc3b_mem_data l2_mem_wdata
`ifdef L2_SCHED_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_i_grants,
  output logic [PERF_W-1:0] perf_d_grants,
  output logic [PERF_W-1:0] perf_conflicts
`endif
);

  logic            load_i;
  logic            load_d;
  logic            clear;
  l2_sched_state_t state;

  l2_sched_control #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_control (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_pmem_read (i_pmem_read),
    .d_pmem_read (d_pmem_read),
    .d_pmem_write(d_pmem_write),
    .l2_mem_resp (l2_mem_resp),
    .load_i      (load_i),
    .load_d      (load_d),
    .clear       (clear),
    .i_pmem_resp (i_pmem_resp),
    .d_pmem_resp (d_pmem_resp),
    .state       (state)
  );

  assign i_pmem_rdata = l2_mem_rdata;
  assign d_pmem_rdata = l2_mem_rdata;

  // L2 request registers: loaded from the winner in IDLE, strobes cleared on completion.
  // A D request with both read and write set issues the writeback first.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      l2_mem_read    <= 1'b0;
      l2_mem_write   <= 1'b0;
      l2_mem_address <= '0;
      l2_mem_wdata   <= '0;
    end else if (state == IDLE) begin
      if (load_i) begin
        l2_mem_read    <= 1'b1;
        l2_mem_write   <= 1'b0;
        l2_mem_address <= i_pmem_address;
      end else if (load_d) begin
        l2_mem_read    <= ~d_pmem_write;
        l2_mem_write   <= d_pmem_write;
        l2_mem_address <= d_pmem_address;
        l2_mem_wdata   <= d_pmem_wdata;
      end
    end else if (clear) begin
      l2_mem_read  <= 1'b0;
      l2_mem_write <= 1'b0;
    end
  end

`ifdef L2_SCHED_PERF_EN
  logic conflict;

  assign conflict = (load_i | load_d) && i_pmem_read && (d_pmem_read | d_pmem_write);

  // Saturating performance counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_i_grants  <= '0;
      perf_d_grants  <= '0;
      perf_conflicts <= '0;
    end else begin
      if (load_i && (perf_i_grants != '1)) begin
        perf_i_grants <= perf_i_grants + 1'b1;
      end
      if (load_d && (perf_d_grants != '1)) begin
        perf_d_grants <= perf_d_grants + 1'b1;
      end
      if (conflict && (perf_conflicts != '1)) begin
        perf_conflicts <= perf_conflicts + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_l2_port_scheduler.sv
// Randomized bench for l2_port_scheduler: cache agents and an L2 responder drive the DUT,
// a transaction-level model predicts every output each cycle.
module tb_l2_port_scheduler;

  localparam int unsigned STARVE_LIMIT = 4;
  localparam int NCYC = 4000;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         i_pmem_read = 1'b0;
  logic [15:0]  i_pmem_address = '0;
  logic         d_pmem_read = 1'b0;
  logic         d_pmem_write = 1'b0;
  logic [15:0]  d_pmem_address = '0;
  logic [127:0] d_pmem_wdata = '0;
  logic         l2_mem_resp = 1'b0;
  logic [127:0] l2_mem_rdata = '0;
  logic         i_pmem_resp;
  logic         d_pmem_resp;
  logic [127:0] i_pmem_rdata;
  logic [127:0] d_pmem_rdata;
  logic         l2_mem_read;
  logic         l2_mem_write;
  logic [15:0]  l2_mem_address;
  logic [127:0] l2_mem_wdata;
`ifdef L2_SCHED_PERF_EN
  logic [15:0]  perf_i_grants;
  logic [15:0]  perf_d_grants;
  logic [15:0]  perf_conflicts;
`endif

  l2_port_scheduler #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .i_pmem_read   (i_pmem_read),
    .i_pmem_address(i_pmem_address),
    .d_pmem_read   (d_pmem_read),
    .d_pmem_write  (d_pmem_write),
    .d_pmem_address(d_pmem_address),
    .d_pmem_wdata  (d_pmem_wdata),
    .l2_mem_resp   (l2_mem_resp),
    .l2_mem_rdata  (l2_mem_rdata),
    .i_pmem_resp   (i_pmem_resp),
    .d_pmem_resp   (d_pmem_resp),
    .i_pmem_rdata  (i_pmem_rdata),
    .d_pmem_rdata  (d_pmem_rdata),
    .l2_mem_read   (l2_mem_read),
    .l2_mem_write  (l2_mem_write),
    .l2_mem_address(l2_mem_address),
    .l2_mem_wdata  (l2_mem_wdata)
`ifdef L2_SCHED_PERF_EN
    ,
    .perf_i_grants (perf_i_grants),
    .perf_d_grants (perf_d_grants),
    .perf_conflicts(perf_conflicts)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: who owns the port (0 none, 1 I, 2 D) and what L2 should see.
  int           owner;
  int           starve;
  logic         m_read, m_write;
  logic [15:0]  m_addr;
  logic [127:0] m_wdata;
  int           lat;
  int           n_i, n_d, n_conf, n_forced;
  logic         prev_i_resp, prev_d_resp;

  task automatic model_reset();
    owner = 0; starve = 0; m_read = 0; m_write = 0; m_addr = '0; m_wdata = '0; lat = 0;
    n_i = 0; n_d = 0; n_conf = 0;
    prev_i_resp = 0; prev_d_resp = 0;
  endtask

  function automatic logic [127:0] rand_line();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic drive_agents();
    if (prev_i_resp) i_pmem_read = 1'b0;
    else if (i_pmem_read && ($urandom % 100) < 3) i_pmem_read = 1'b0;
    if (!i_pmem_read && ($urandom % 100) < 35) begin
      i_pmem_read    = 1'b1;
      i_pmem_address = 16'($urandom);
    end
    if (prev_d_resp) begin
      if (d_pmem_write) d_pmem_write = 1'b0;
      else d_pmem_read = 1'b0;
    end else if ((d_pmem_read || d_pmem_write) && ($urandom % 100) < 3) begin
      d_pmem_read  = 1'b0;
      d_pmem_write = 1'b0;
    end
    if (!(d_pmem_read || d_pmem_write) && ($urandom % 100) < 70) begin
      case ($urandom % 4)
        0, 1:    begin d_pmem_read = 1'b1; d_pmem_write = 1'b0; end
        2:       begin d_pmem_read = 1'b0; d_pmem_write = 1'b1; end
        default: begin d_pmem_read = 1'b1; d_pmem_write = 1'b1; end
      endcase
      d_pmem_address = 16'($urandom);
      d_pmem_wdata   = rand_line();
    end
  endtask

  task automatic drive_l2();
    l2_mem_resp  = 1'b0;
    l2_mem_rdata = rand_line();
    if (owner != 0) begin
      if (lat == 0) l2_mem_resp = 1'b1;
      else lat--;
    end else if (($urandom % 100) < 5) begin
      l2_mem_resp = 1'b1;
    end
  endtask

  task automatic compare();
    logic ei, ed;
    ei = (owner == 1) && l2_mem_resp;
    ed = (owner == 2) && l2_mem_resp;
    check_eq("l2_mem_read", 128'(l2_mem_read), 128'(m_read));
    check_eq("l2_mem_write", 128'(l2_mem_write), 128'(m_write));
    check_eq("l2_mem_address", 128'(l2_mem_address), 128'(m_addr));
    check_eq("l2_mem_wdata", l2_mem_wdata, m_wdata);
    check_eq("i_pmem_resp", 128'(i_pmem_resp), 128'(ei));
    check_eq("d_pmem_resp", 128'(d_pmem_resp), 128'(ed));
    check_eq("i_pmem_rdata", i_pmem_rdata, l2_mem_rdata);
    check_eq("d_pmem_rdata", d_pmem_rdata, l2_mem_rdata);
    prev_i_resp = ei;
    prev_d_resp = ed;
  endtask

  // Apply the arbitration rules to the inputs present before the coming edge.
  task automatic model_step();
    logic i_req, d_req;
    i_req = i_pmem_read;
    d_req = d_pmem_read || d_pmem_write;
    if (owner == 0) begin
      if (i_req && d_req) n_conf++;
      if (i_req && (starve == STARVE_LIMIT || !d_req)) begin
        if (d_req) n_forced++;
        owner = 1; m_read = 1; m_write = 0; m_addr = i_pmem_address;
        starve = 0; n_i++; lat = $urandom_range(0, 3);
      end else if (d_req) begin
        owner = 2; m_write = d_pmem_write; m_read = !d_pmem_write;
        m_addr = d_pmem_address; m_wdata = d_pmem_wdata;
        starve = i_req ? ((starve < STARVE_LIMIT) ? starve + 1 : starve) : 0;
        n_d++; lat = $urandom_range(0, 3);
      end else begin
        starve = 0;
      end
    end else if (l2_mem_resp) begin
      owner = 0; m_read = 0; m_write = 0;
    end
  endtask

  // Async reset mid-cycle: strobes must fall without waiting for a clock edge.
  task automatic mid_reset();
    reset_n = 1'b0;
    l2_mem_resp = 1'b0;
    #1;
    check_eq("async_rst_read", 128'(l2_mem_read), 128'(0));
    check_eq("async_rst_write", 128'(l2_mem_write), 128'(0));
    check_eq("async_rst_addr", 128'(l2_mem_address), 128'(0));
    check_eq("async_rst_d_resp", 128'(d_pmem_resp), 128'(0));
    i_pmem_read = 1'b0; d_pmem_read = 1'b0; d_pmem_write = 1'b0;
    model_reset();
    @(posedge clk);
    #2;
    reset_n = 1'b1;
  endtask

  int n_resets;

  initial begin
    model_reset();
    n_forced = 0;
    n_resets = 0;
    repeat (2) @(negedge clk);
    #1;
    check_eq("reset_read", 128'(l2_mem_read), 128'(0));
    check_eq("reset_write", 128'(l2_mem_write), 128'(0));
    check_eq("reset_addr", 128'(l2_mem_address), 128'(0));
    check_eq("reset_wdata", l2_mem_wdata, 128'(0));
    check_eq("reset_i_resp", 128'(i_pmem_resp), 128'(0));
    check_eq("reset_d_resp", 128'(d_pmem_resp), 128'(0));
    reset_n = 1'b1;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      drive_agents();
      drive_l2();
      #1;
      compare();
      if (owner == 2 && n_resets < 6 && ($urandom % 64) == 0) begin
        n_resets++;
        mid_reset();
      end else begin
        model_step();
      end
    end
`ifdef L2_SCHED_PERF_EN
    @(negedge clk);
    check_eq("perf_i_grants", 128'(perf_i_grants), 128'(n_i));
    check_eq("perf_d_grants", 128'(perf_d_grants), 128'(n_d));
    check_eq("perf_conflicts", 128'(perf_conflicts), 128'(n_conf));
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
